exp4_unidade_controle: RTL and testbench

Control unit for the memory-sequence game: a Moore state machine that sequences the 16-entry datapath. It resets the address counter and switch register, waits for each player move, captures the switches, checks the comparison result, and advances the address. It also detects the end of the sequence and reports success or failure. The block sits directly beside the datapath: it drives `zeraC`, `contaC`, `zeraR` and `registraR`, and it consumes `chavesIgualMemoria` and `fimC`.

---
 rtl/exp4_pkg.sv | 35 +++
 rtl/edge_detector.sv | 33 +++
 rtl/exp4_unidade_controle.sv | 113 +++++++++++
 tb/tb_exp4_unidade_controle.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/exp4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exp4_pkg
//  Description : Shared state codes for the memory-sequence game control unit.
//                ESTADO_W is the width of the state code. The localparams
//                hold the fixed 4-bit code of each state. estado_t is the
//                enumerated state type built on those codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package exp4_pkg;

    localparam int ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] INICIAL     = 4'b0000;
    localparam logic [ESTADO_W-1:0] PREPARA     = 4'b0001;
    localparam logic [ESTADO_W-1:0] ESPERA      = 4'b0010;
    localparam logic [ESTADO_W-1:0] REGISTRA    = 4'b0100;
    localparam logic [ESTADO_W-1:0] COMPARA     = 4'b0101;
    localparam logic [ESTADO_W-1:0] PROXIMO     = 4'b0110;
    localparam logic [ESTADO_W-1:0] FIM_ACERTOU = 4'b1010;
    localparam logic [ESTADO_W-1:0] FIM_ERROU   = 4'b1110;

    typedef enum logic [ESTADO_W-1:0] {
        E_INICIAL     = INICIAL,
        E_PREPARA     = PREPARA,
        E_ESPERA      = ESPERA,
        E_REGISTRA    = REGISTRA,
        E_COMPARA     = COMPARA,
        E_PROXIMO     = PROXIMO,
        E_FIM_ACERTOU = FIM_ACERTOU,
        E_FIM_ERROU   = FIM_ERROU
    } estado_t;

endpackage : exp4_pkg
`default_nettype wire

// File: rtl/edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detector
//  Description : Rising-edge detector. pulso is high while sinal is high and
//                the previous sampled value was low, so a held level gives one
//                single-cycle pulse.
//  Ports       : clock   - system clock, rising edge
//                reset_n - asynchronous active-low reset
//                sinal   - level input, synchronous to clock
//                pulso   - one-cycle rising-edge pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detector (
    input  logic clock,
    input  logic reset_n,
    input  logic sinal,
    output logic pulso
);

    logic sinal_ant_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sinal_ant_q <= 1'b0;
        end else begin
            sinal_ant_q <= sinal;
        end
    end

    assign pulso = sinal & ~sinal_ant_q;

endmodule : edge_detector
`default_nettype wire

// File: rtl/exp4_unidade_controle.sv
`default_nettype none
// ============================================================================
//  Module      : exp4_unidade_controle
//  Description : Moore control unit for the memory-sequence game. It clears
//                the datapath, waits for player moves, loads the switches,
//                checks the comparison and advances the address until the
//                end of the sequence or the first mismatch.
//  Ports       : clock, reset_n (async, active-low)
//                iniciar            - start / restart request
//                chaves[3:0]        - player switches (move = rise of |chaves)
//                igual, fimC        - datapath status
//                zeraC, contaC      - counter clear / increment
//                zeraR, registraR   - switch register clear / load
//                pronto, acertou, errou - game result
//                db_estado[3:0]     - current state code
//  Revision    : 1.0 - initial release
// ============================================================================
module exp4_unidade_controle
    import exp4_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                iniciar,
    input  logic [3:0]          chaves,
    input  logic                igual,
    input  logic                fimC,
    output logic                zeraC,
    output logic                contaC,
    output logic                zeraR,
    output logic                registraR,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    logic    w_jogada;

    edge_detector u_detector_jogada (
        .clock   (clock),
        .reset_n (reset_n),
        .sinal   (|chaves),
        .pulso   (w_jogada)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= E_INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next state. iniciar is only looked at in INICIAL and the FIM states,
    // so a move together with iniciar in ESPERA is handled as a move only.
    always_comb begin
        estado_d = E_INICIAL;
        case (estado_q)
            E_INICIAL:     estado_d = iniciar ? E_PREPARA : E_INICIAL;
            E_PREPARA:     estado_d = E_ESPERA;
            E_ESPERA:      estado_d = w_jogada ? E_REGISTRA : E_ESPERA;
            E_REGISTRA:    estado_d = E_COMPARA;
            // A mismatch wins over terminal count.
            E_COMPARA: begin
                if (!igual) begin
                    estado_d = E_FIM_ERROU;
                end else if (fimC) begin
                    estado_d = E_FIM_ACERTOU;
                end else begin
                    estado_d = E_PROXIMO;
                end
            end
            E_PROXIMO:     estado_d = E_ESPERA;
            E_FIM_ACERTOU: estado_d = iniciar ? E_PREPARA : E_FIM_ACERTOU;
            E_FIM_ERROU:   estado_d = iniciar ? E_PREPARA : E_FIM_ERROU;
            default:       estado_d = E_INICIAL;
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        case (estado_q)
            E_PREPARA: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            E_REGISTRA:    registraR = 1'b1;
            E_PROXIMO:     contaC    = 1'b1;
            E_FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            E_FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule : exp4_unidade_controle
`default_nettype wire

// File: tb/tb_exp4_unidade_controle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp4_unidade_controle
//  Description : Self-checking bench for exp4_unidade_controle, with a small
//                datapath (address counter, synchronous ROM, switch register).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exp4_unidade_controle;

    // State codes taken directly from the state table.
    localparam logic [3:0] C_INI = 4'b0000, C_PRE = 4'b0001, C_ESP = 4'b0010,
                           C_REG = 4'b0100, C_CMP = 4'b0101, C_PRX = 4'b0110,
                           C_ACE = 4'b1010, C_ERR = 4'b1110;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'b0000;
    logic       igual, fimC;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;
    int n_conta = 0;

    // Datapath environment.
    logic [3:0] rom [16];
    logic [3:0] cnt_q, rom_q, reg_q;

    always #5 clock = ~clock;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
            rom_q <= 4'd0;
            reg_q <= 4'd0;
        end else begin
            if (zeraC)       cnt_q <= 4'd0;
            else if (contaC) cnt_q <= cnt_q + 4'd1;
            if (zeraR)          reg_q <= 4'd0;
            else if (registraR) reg_q <= chaves;
            rom_q <= rom[cnt_q];
        end
    end

    assign igual = (reg_q == rom_q);
    assign fimC  = (cnt_q == 4'd15);

    exp4_unidade_controle dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .iniciar   (iniciar),
        .chaves    (chaves),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .db_estado (db_estado)
    );

    // Expected strobes per state: {zeraC,contaC,zeraR,registraR,pronto,acertou,errou}
    function automatic logic [6:0] exp_outs(input logic [3:0] code);
        case (code)
            C_PRE:   return 7'b1010000;
            C_REG:   return 7'b0001000;
            C_PRX:   return 7'b0100000;
            C_ACE:   return 7'b0000110;
            C_ERR:   return 7'b0000101;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] code);
        chk({tag, ".estado"}, {28'd0, db_estado}, {28'd0, code});
        chk({tag, ".saidas"}, {25'd0, zeraC, contaC, zeraR, registraR, pronto, acertou, errou},
            {25'd0, exp_outs(code)});
    endtask

    task automatic tick();
        @(negedge clock);
        if (contaC === 1'b1) n_conta++;
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        chk_state("inicio.prepara", C_PRE);
        iniciar = 1'b0;
        n_conta = 0;
        tick();
        chk_state("inicio.espera", C_ESP);
        chk("inicio.endereco", {28'd0, cnt_q}, 32'd0);
    endtask

    // Plays one move at address idx; the expected verdict follows the game
    // rule directly: wrong value ends in error, last address ends in success.
    task automatic play_move(input logic [3:0] m, input int idx);
        logic [3:0] exp_code;
        int idle;
        idle = $urandom_range(0, 3);
        for (int k = 0; k < idle; k++) begin
            iniciar = 1'($urandom_range(0, 1));
            tick();
            chk_state("espera.ocioso", C_ESP);
        end
        chaves  = m;
        iniciar = 1'($urandom_range(0, 1));
        tick();
        chk_state("jogada.registra", C_REG);
        iniciar = 1'b0;
        tick();
        chk_state("jogada.compara", C_CMP);
        chk("jogada.endereco", {28'd0, cnt_q}, idx);
        chaves = 4'b0000;
        tick();
        if (m != rom[idx])   exp_code = C_ERR;
        else if (idx == 15)  exp_code = C_ACE;
        else                 exp_code = C_PRX;
        chk_state("jogada.veredito", exp_code);
        if (exp_code == C_PRX) begin
            tick();
            chk_state("jogada.volta_espera", C_ESP);
        end
    endtask

    task automatic random_rom();
        for (int k = 4; k < 16; k++) rom[k] = 4'($urandom_range(1, 15));
    endtask

    initial begin
        int regs;
        logic [3:0] m;
        rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
        random_rom();

        // Reset state
        #2;
        chk_state("reset", C_INI);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_state("inicial.parado", C_INI);
        end

        // Full correct game
        start_game();
        for (int i = 0; i < 16; i++) play_move(rom[i], i);
        chk("acerto.n_conta", n_conta, 32'd15);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_state("acerto.mantem", C_ACE);
        end

        // Mismatch at address 2
        start_game();
        play_move(4'b0001, 0);
        play_move(4'b0010, 1);
        play_move(4'b0001, 2);
        tick();
        chk_state("erro.mantem", C_ERR);
        chk("erro.endereco", {28'd0, cnt_q}, 32'd2);

        // Restart from error, one correct move
        start_game();
        play_move(4'b0001, 0);

        // Held key: exactly one move
        chaves = rom[1];
        regs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (db_estado === C_REG) regs++;
        end
        chk("segurado.registros", regs, 32'd1);
        chk_state("segurado.espera", C_ESP);
        chaves = 4'b0000;
        tick();
        chk_state("soltou.espera", C_ESP);
        play_move(rom[2], 2);

        // Asynchronous reset while in COMPARA
        chaves = rom[3];
        tick();
        tick();
        chk_state("pre_reset.compara", C_CMP);
        #2 reset_n = 1'b0;
        #1;
        chk_state("reset_assincrono", C_INI);
        chaves = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk_state("pos_reset", C_INI);

        // Randomized games against the game rule
        for (int g = 0; g < 6; g++) begin
            random_rom();
            start_game();
            for (int i = 0; i < 16; i++) begin
                m = rom[i];
                if ($urandom_range(0, 9) == 0) begin
                    m = 4'($urandom_range(1, 15));
                    if (m == rom[i]) m = m ^ 4'b0001;
                    if (m == 4'b0000) m = 4'b0010;
                end
                play_move(m, i);
                if (m != rom[i]) begin
                    chk("aleat.n_conta_erro", n_conta, i);
                    break;
                end
                if (i == 15) chk("aleat.n_conta_acerto", n_conta, 32'd15);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_exp4_unidade_controle
`default_nettype wire
